// File: rtl/ssr_pkg.sv
// Shared definitions for the SSR sequencer: state codes and command word field layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ssr_pkg;

    // State codes are visible on state_o, so the encoding is part of the register map.
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ON    = 2'd1,
        ST_FAULT = 2'd2
    } ssr_state_t;

    // Command word bit positions.
    localparam int CMD_ON       = 0;
    localparam int CMD_PWM      = 1;
    localparam int CMD_DUTY_LSB = 8;
    localparam int CMD_DUTY_MSB = 15;
    localparam int CMD_FCLR     = 31;

    // Latched copy of the command fields that persist between strobes.
    typedef struct packed {
        logic [7:0] duty;
        logic       pwm;
        logic       on;
    } cmd_t;

endpackage

// File: rtl/ssr_tick_gen.sv
// Control-tick prescaler plus free-running 8-bit PWM phase for time-proportioned firing.
// Latency: tick is combinational from the prescaler; pwm_phase advances on the tick edge.
// Backpressure: none; free-running from reset.
//
// Ports:
//   clk        system clock
//   clr        synchronous active-low reset
//   tick       1-cycle pulse every PRESCALE clocks
//   pwm_phase  8-bit phase, +1 per tick, wraps 255->0
module ssr_tick_gen #(
    parameter int PRESCALE = 100000
) (
    input  logic       clk,
    input  logic       clr,
    output logic       tick,
    output logic [7:0] pwm_phase
);

    localparam int PW = $clog2(PRESCALE + 1);

    logic [PW-1:0] pre_cnt;

    assign tick = (pre_cnt == PW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (!clr) begin
            pre_cnt   <= '0;
            pwm_phase <= '0;
        end else if (tick) begin
            pre_cnt   <= '0;
            pwm_phase <= pwm_phase + 8'd1;
        end else begin
            pre_cnt   <= pre_cnt + PW'(1);
        end
    end

endmodule

// File: rtl/ssr_sequencer.sv
// Solid-state-relay sequencer: enforces min on/off dwell, max-on watchdog and optional slow-PWM firing.
// Latency: command strobed at edge N changes state at edge N+1 when dwell allows; jc[0] follows state.
// Backpressure: none; requests arriving during dwell are held and acted on once dwell expires.
//
// Ports:
//   clk        system clock
//   clr        synchronous active-low reset (also gates jc[0] combinationally)
//   command    [0] on_req, [1] pwm_mode, [15:8] duty, [31] fault_clear
//   cmd_valid  1-cycle strobe sampling command
//   jc         jc[0] relay drive, jc[7:1] high-Z
//   ssr_on     registered state==ON
//   fault      registered state==FAULT
//   state_o    current state code
module ssr_sequencer
    import ssr_pkg::*;
#(
    parameter int PRESCALE     = 100000,
    parameter int MIN_DWELL    = 20,
    parameter int MAX_ON_TICKS = 60000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] command,
    input  logic        cmd_valid,
    output logic [7:0]  jc,
    output logic        ssr_on,
    output logic        fault,
    output logic [1:0]  state_o
);

    localparam int DW = $clog2(MIN_DWELL + 1);
    localparam int OW = $clog2(MAX_ON_TICKS + 1);

    logic          tick;
    logic [7:0]    pwm_phase;
    cmd_t          cmd_reg;
    ssr_state_t    state;
    ssr_state_t    state_nxt;
    logic [DW-1:0] dwell_cnt;
    logic [OW-1:0] on_cnt;
    logic          desired;
    logic          dwell_done;
    logic          watchdog_hit;
    logic          unused_cmd_bits;

    // Bits of the command word with no meaning here.
    assign unused_cmd_bits = ^{command[30:16], command[7:2]};

    ssr_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk       (clk),
        .clr       (clr),
        .tick      (tick),
        .pwm_phase (pwm_phase)
    );

    // Duty 255 still leaves phase 255 off: strict less-than comparison.
    assign desired      = cmd_reg.on & (cmd_reg.pwm ? (pwm_phase < cmd_reg.duty) : 1'b1);
    assign dwell_done   = (dwell_cnt == DW'(MIN_DWELL));
    assign watchdog_hit = tick & (on_cnt == OW'(MAX_ON_TICKS - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_OFF: begin
                if (desired && dwell_done)
                    state_nxt = ST_ON;
            end
            ST_ON: begin
                // Watchdog takes priority over a turn-off landing on the same tick.
                if (watchdog_hit)
                    state_nxt = ST_FAULT;
                else if (!desired && dwell_done)
                    state_nxt = ST_OFF;
            end
            ST_FAULT: begin
                // Clear only when the same write does not also request on.
                if (cmd_valid && command[CMD_FCLR] && !command[CMD_ON])
                    state_nxt = ST_OFF;
            end
            default: state_nxt = ST_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            cmd_reg   <= '0;
            state     <= ST_OFF;
            dwell_cnt <= DW'(MIN_DWELL);   // saturated: first turn-on needs no wait
            on_cnt    <= '0;
            ssr_on    <= 1'b0;
            fault     <= 1'b0;
        end else begin
            if (cmd_valid) begin
                cmd_reg.on   <= command[CMD_ON];
                cmd_reg.pwm  <= command[CMD_PWM];
                cmd_reg.duty <= command[CMD_DUTY_MSB:CMD_DUTY_LSB];
            end

            state <= state_nxt;

            if (state_nxt != state)
                dwell_cnt <= '0;
            else if (tick && !dwell_done)
                dwell_cnt <= dwell_cnt + DW'(1);

            // Leaving ON at the watchdog limit keeps on_cnt below MAX_ON_TICKS.
            if (state == ST_ON && state_nxt == ST_ON) begin
                if (tick)
                    on_cnt <= on_cnt + OW'(1);
            end else begin
                on_cnt <= '0;
            end

            ssr_on <= (state_nxt == ST_ON);
            fault  <= (state_nxt == ST_FAULT);
        end
    end

    assign jc[0]   = (state == ST_ON) & clr;
    assign jc[7:1] = 7'bz;
    assign state_o = state;

endmodule

// File: tb/tb_ssr_sequencer.sv
// Directed bench for ssr_sequencer with PRESCALE=4, MIN_DWELL=3, MAX_ON_TICKS=50.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_ssr_sequencer;

    logic        clk;
    logic        clr;
    logic [31:0] command;
    logic        cmd_valid;
    logic [7:0]  jc;
    logic        ssr_on;
    logic        fault;
    logic [1:0]  state_o;

    int nchk;
    int npass;

    ssr_sequencer #(
        .PRESCALE     (4),
        .MIN_DWELL    (3),
        .MAX_ON_TICKS (50)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .command   (command),
        .cmd_valid (cmd_valid),
        .jc        (jc),
        .ssr_on    (ssr_on),
        .fault     (fault),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] c);
        command   = c;
        cmd_valid = 1'b1;
        step(1);
        cmd_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        int hi;
        int fc;
        nchk      = 0;
        npass     = 0;
        clr       = 1'b0;
        command   = 32'h0;
        cmd_valid = 1'b0;

        // Reset held for 5 clocks.
        step(5);
        chk("rst_jc0",    32'(jc[0]),   32'd0);
        chk("rst_state",  32'(state_o), 32'd0);
        chk("rst_ssr_on", 32'(ssr_on),  32'd0);
        chk("rst_fault",  32'(fault),   32'd0);

        // Direct on (strobe at edge 1), then off strobed at edge 2.
        clr       = 1'b1;
        command   = 32'h1;
        cmd_valid = 1'b1;
        step(1);                                   // edge 1
        command   = 32'h0;
        chk("on_latency_not_yet", 32'(jc[0]), 32'd0);
        step(1);                                   // edge 2: ON
        cmd_valid = 1'b0;
        chk("on_jc0",    32'(jc[0]),   32'd1);
        chk("on_state",  32'(state_o), 32'd1);
        chk("on_ssr_on", 32'(ssr_on),  32'd1);
        step(10);                                  // edge 12: third tick just taken
        chk("on_dwell_hold", 32'(jc[0]), 32'd1);
        step(1);                                   // edge 13: OFF
        chk("off_after_dwell", 32'(jc[0]),   32'd0);
        chk("off_state",       32'(state_o), 32'd0);

        // Re-request on immediately: must wait out the off dwell.
        strobe(32'h1);                             // edge 14
        chk("reon_blocked", 32'(jc[0]), 32'd0);
        step(10);                                  // edge 24
        chk("reon_dwell_hold", 32'(jc[0]), 32'd0);
        step(1);                                   // edge 25: ON
        chk("reon_after_dwell", 32'(jc[0]), 32'd1);

        // Watchdog: 50th tick in ON lands on edge 224.
        step(198);                                 // edge 223
        chk("wd_still_on", 32'(state_o), 32'd1);
        step(1);                                   // edge 224
        chk("wd_state",  32'(state_o), 32'd2);
        chk("wd_fault",  32'(fault),   32'd1);
        chk("wd_jc0",    32'(jc[0]),   32'd0);
        chk("wd_ssr_on", 32'(ssr_on),  32'd0);

        strobe(32'h8000_0001);                     // edge 225: clear with on_req ignored
        chk("fclr_with_on_ignored", 32'(state_o), 32'd2);
        strobe(32'h8000_0000);                     // edge 226: clear
        chk("fclr_state", 32'(state_o), 32'd0);
        chk("fclr_fault", 32'(fault),   32'd0);
        strobe(32'h1);                             // edge 227
        chk("post_fault_blocked", 32'(state_o), 32'd0);
        step(9);                                   // edge 236
        chk("post_fault_dwell_hold", 32'(state_o), 32'd0);
        step(1);                                   // edge 237: ON
        chk("post_fault_on", 32'(state_o), 32'd1);

        // Off request lands on the same tick that hits the watchdog (edge 436).
        step(197);                                 // edge 434
        strobe(32'h0);                             // edge 435
        chk("simul_pre_on", 32'(state_o), 32'd1);
        step(1);                                   // edge 436
        chk("simul_fault_wins", 32'(state_o), 32'd2);
        chk("simul_fault_flag", 32'(fault),   32'd1);
        strobe(32'h8000_0000);                     // edge 437
        chk("simul_clear", 32'(state_o), 32'd0);

        // PWM, duty 0x28: 40 of 256 ticks on -> 160 of 1024 clocks.
        strobe(32'h0000_2803);
        step(1100);
        hi = 0;
        fc = 0;
        for (int i = 0; i < 1024; i++) begin
            if (jc[0])
                hi++;
            if (fault)
                fc++;
            step(1);
        end
        chk("pwm_high_clocks", 32'(hi), 32'd160);
        chk("pwm_no_fault",    32'(fc), 32'd0);

        // PWM duty 0: never on.
        strobe(32'h0000_0003);
        step(60);
        hi = 0;
        for (int i = 0; i < 1100; i++) begin
            if (jc[0])
                hi++;
            step(1);
        end
        chk("pwm_duty0_off", 32'(hi), 32'd0);

        // Reset mid-ON.
        strobe(32'h1);
        chk("mid_pre_off", 32'(jc[0]), 32'd0);
        step(1);
        chk("mid_on", 32'(jc[0]), 32'd1);
        clr = 1'b0;
        #1;
        chk("mid_reset_comb_drop", 32'(jc[0]), 32'd0);
        step(2);
        clr = 1'b1;
        chk("mid_reset_state", 32'(state_o), 32'd0);
        step(20);
        chk("mid_cmd_cleared", 32'(state_o), 32'd0);
        strobe(32'h1);
        chk("mid_restrobe_latency", 32'(state_o), 32'd0);
        step(1);
        chk("mid_on_no_wait", 32'(state_o), 32'd1);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
